sfa_in_switch_arb: RTL and testbench

- Parametrised, registered N-to-1 AXI-Stream input switch for an SFA compute node.
- Selects one of N_CH slave streams onto the single master stream feeding the processing element.
- Two selection modes, chosen at runtime:
  - static: channel given by CONF.
  - round-robin: arbitrated among valid channels.
- Switching happens only at packet boundaries (TLAST). The output is fully registered through a 2-entry skid buffer.

---
 rtl/sfa_in_switch_arb.sv | 184 ++++++++++++++++++
 tb/tb_sfa_in_switch_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfa_in_switch_arb.sv
// sfa_in_switch_arb: registered N-to-1 AXI-Stream input switch.
// Selects one slave stream (static CONF or round-robin) onto the master
// stream, switching only at packet boundaries, through a 2-entry skid buffer.
module sfa_in_switch_arb #(
    parameter int N_CH  = 4,
    parameter int DW    = 32,
    parameter int SEL_W = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 MODE,
    input  logic [SEL_W-1:0]     CONF,
    input  logic [N_CH-1:0]      s_tvalid,
    input  logic [N_CH*DW-1:0]   s_tdata,
    input  logic [N_CH-1:0]      s_tlast,
    output logic [N_CH-1:0]      s_tready,
    output logic                 mi_tvalid,
    output logic [DW-1:0]        mi_tdata,
    output logic                 mi_tlast,
    input  logic                 mi_tready,
    output logic [SEL_W-1:0]     GRANT,
    output logic                 BUSY
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [SEL_W-1:0]  grant, grant_nxt;

    // Output stage: main register drives mi_*, skid catches one beat under backpressure
    logic              main_valid, skid_valid;
    logic [DW-1:0]     main_data,  skid_data;
    logic              main_last,  skid_last;

    // Granted channel view
    logic              sel_valid;
    logic              sel_last;
    logic [DW-1:0]     sel_data;
    logic              conf_valid;

    // Round-robin search results
    logic              hi_found, lo_found;
    logic [SEL_W-1:0]  hi_idx,   lo_idx;

    logic              accept;
    logic              drain;

    // Mux the granted channel and the statically configured channel's valid
    always_comb begin
        sel_valid  = 1'b0;
        sel_last   = 1'b0;
        sel_data   = '0;
        conf_valid = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == grant) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DW +: DW];
            end
            if (SEL_W'(i) == CONF) begin
                conf_valid = s_tvalid[i];
            end
        end
    end

    // Cyclic search from grant+1 to grant: prefer lowest valid index above
    // grant, else wrap to lowest valid index at or below grant
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (s_tvalid[i]) begin
                if (SEL_W'(i) > grant) begin
                    if (!hi_found) begin
                        hi_found = 1'b1;
                        hi_idx   = SEL_W'(i);
                    end
                end else begin
                    if (!lo_found) begin
                        lo_found = 1'b1;
                        lo_idx   = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Ready depends only on registered state, never on mi_tready
    always_comb begin
        s_tready = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            s_tready[i] = (state == ST_PASS) && !skid_valid && (SEL_W'(i) == grant);
        end
    end

    assign accept = (state == ST_PASS) && sel_valid && !skid_valid;
    assign drain  = main_valid && mi_tready;

    // Next-state and grant selection
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            ST_ARB: begin
                if (!MODE) begin
                    grant_nxt = CONF;
                    if (conf_valid) begin
                        state_nxt = ST_PASS;
                    end
                end else begin
                    if (hi_found) begin
                        grant_nxt = hi_idx;
                        state_nxt = ST_PASS;
                    end else if (lo_found) begin
                        grant_nxt = lo_idx;
                        state_nxt = ST_PASS;
                    end
                end
            end
            ST_PASS: begin
                if (accept && sel_last) begin
                    state_nxt = ST_ARB;
                end
            end
            default: begin
                state_nxt = ST_ARB;
            end
        endcase
    end

    // State and grant registers
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state <= ST_ARB;
            grant <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Main/skid buffer: skid refills main on drain; accepted beat goes to
    // main when it is empty or draining, else into skid
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_last  <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                main_data  <= skid_data;
                main_last  <= skid_last;
                skid_valid <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid || drain) begin
                main_valid <= 1'b1;
                main_data  <= sel_data;
                main_last  <= sel_last;
            end else begin
                skid_valid <= 1'b1;
                skid_data  <= sel_data;
                skid_last  <= sel_last;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

    assign mi_tvalid = main_valid;
    assign mi_tdata  = main_data;
    assign mi_tlast  = main_last;
    assign GRANT     = grant;
    assign BUSY      = (state == ST_PASS);

endmodule

// File: tb/tb_sfa_in_switch_arb.sv
// Testbench for sfa_in_switch_arb: directed packets, scoreboard of expected
// master beats and expected grant events, monitor on the falling edge.
module tb_sfa_in_switch_arb;

    localparam int N_CH  = 4;
    localparam int DW    = 32;
    localparam int SEL_W = 2;

    typedef logic [DW:0] beat_t;
    typedef struct {
        int grant;
        int gap;
    } rise_t;

    logic               clk;
    logic               ARESET;
    logic               MODE;
    logic [SEL_W-1:0]   CONF;
    logic [N_CH-1:0]    s_tvalid;
    logic [N_CH*DW-1:0] s_tdata;
    logic [N_CH-1:0]    s_tlast;
    logic [N_CH-1:0]    s_tready;
    logic               mi_tvalid;
    logic [DW-1:0]      mi_tdata;
    logic               mi_tlast;
    logic               mi_tready;
    logic [SEL_W-1:0]   GRANT;
    logic               BUSY;

    sfa_in_switch_arb #(.N_CH(N_CH), .DW(DW), .SEL_W(SEL_W)) dut (
        .ACLK      (clk),
        .ARESET    (ARESET),
        .MODE      (MODE),
        .CONF      (CONF),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .mi_tvalid (mi_tvalid),
        .mi_tdata  (mi_tdata),
        .mi_tlast  (mi_tlast),
        .mi_tready (mi_tready),
        .GRANT     (GRANT),
        .BUSY      (BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    beat_t srcq [N_CH][$];
    beat_t exp_q [$];
    rise_t rise_q [$];
    logic [N_CH-1:0] hs = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_src(input int ch, input int base, input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b = {(k == n - 1) ? 1'b1 : 1'b0, 32'(base + k)};
            srcq[ch].push_back(b);
        end
    endtask

    task automatic push_exp(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b = {(k == n - 1) ? 1'b1 : 1'b0, 32'(base + k)};
            exp_q.push_back(b);
        end
    endtask

    task automatic push_rise(input int g, input int gap);
        rise_t r;
        r.grant = g;
        r.gap   = gap;
        rise_q.push_back(r);
    endtask

    function automatic bit src_busy();
        bit any;
        any = (s_tvalid != '0);
        for (int i = 0; i < N_CH; i++) begin
            if (srcq[i].size() != 0) any = 1'b1;
        end
        return any;
    endfunction

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || src_busy() || mi_tvalid) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc >= 300) begin
            n_bad++;
            $display("FAIL drain_%s: pending %0d beats after %0d cycles, required 0", name, exp_q.size(), cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    // Source driver: retire handshaken beats, present next beat of each channel
    initial begin
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N_CH; i++) begin
                beat_t b;
                if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
                if (srcq[i].size() > 0) begin
                    b = srcq[i][0];
                    s_tvalid[i]          = 1'b1;
                    s_tdata[i*DW +: DW]  = b[DW-1:0];
                    s_tlast[i]           = b[DW];
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard pops, hold stability, ready mask, grant events
    logic          prev_hold = 1'b0;
    beat_t         prev_beat = '0;
    logic          busy_d    = 1'b0;
    int            low_run   = 0;
    always @(negedge clk) begin
        logic [N_CH-1:0] mask;
        beat_t act, expb;
        rise_t r;
        hs = s_tvalid & s_tready;
        mask = BUSY ? (N_CH'(1) << GRANT) : '0;
        check("tready_mask", 64'(s_tready & ~mask), 64'(0));
        act = {mi_tlast, mi_tdata};
        if (prev_hold) begin
            check("hold_valid", 64'(mi_tvalid), 64'(1));
            check("hold_beat", 64'(act), 64'(prev_beat));
        end
        prev_hold = mi_tvalid && !mi_tready && !ARESET;
        prev_beat = act;
        if (mi_tvalid && mi_tready && !ARESET) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got %0h expected none", act);
            end else begin
                expb = exp_q.pop_front();
                check("beat", 64'(act), 64'(expb));
            end
        end
        if (BUSY && !busy_d && !ARESET) begin
            if (rise_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_grant: got %0d expected none", GRANT);
            end else begin
                r = rise_q.pop_front();
                check("grant_seq", 64'(GRANT), 64'(r.grant));
                if (r.gap >= 0) check("bubble", 64'(low_run), 64'(r.gap));
            end
        end
        if (BUSY) low_run = 0;
        else low_run++;
        busy_d = BUSY;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_v, exp_b;
        ARESET    = 1'b1;
        MODE      = 1'b0;
        CONF      = 2'd2;
        mi_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1 ARESET = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 64'(mi_tvalid), 64'(0));
        check("rst_data",  64'(mi_tdata),  64'(0));
        check("rst_last",  64'(mi_tlast),  64'(0));
        check("rst_grant", 64'(GRANT),     64'(0));
        check("rst_busy",  64'(BUSY),      64'(0));
        check("rst_ready", 64'(s_tready),  64'(0));

        // 1: static routing of ch2, latency and valid/busy timing
        push_src(2, 'hA0, 4);
        push_exp('hA0, 4);
        push_rise(2, -1);
        exp_v = 8'b0011_1100;
        exp_b = 8'b0001_1110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_valid", 64'(mi_tvalid), 64'(exp_v[i]));
            check("t1_busy",  64'(BUSY),      64'(exp_b[i]));
        end
        wait_drain("t1");

        // 2: backpressure on the same packet
        @(posedge clk);
        #1 mi_tready = 1'b0;
        @(negedge clk);
        push_src(2, 'hA0, 4);
        push_exp('hA0, 4);
        push_rise(2, -1);
        repeat (4) @(negedge clk);
        check("t2_ready_drop", 64'(s_tready[2]), 64'(0));
        check("t2_head",       64'({mi_tvalid, mi_tdata}), 64'({1'b1, 32'hA0}));
        repeat (2) @(posedge clk);
        #1 mi_tready = 1'b1;
        wait_drain("t2");

        // Prime grant to 3 so round-robin starts at channel 0
        @(posedge clk);
        #1 CONF = 2'd3;
        @(negedge clk);
        push_src(3, 'h3F, 1);
        push_exp('h3F, 1);
        push_rise(3, -1);
        wait_drain("prime");

        // 3: round-robin fairness among channels 0, 1, 3
        @(posedge clk);
        #1 MODE = 1'b1;
        @(negedge clk);
        push_src(0, 'h100, 2); push_src(0, 'h102, 2);
        push_src(1, 'h110, 2); push_src(1, 'h112, 2);
        push_src(3, 'h130, 2); push_src(3, 'h132, 2);
        push_exp('h100, 2); push_exp('h110, 2); push_exp('h130, 2);
        push_exp('h102, 2); push_exp('h112, 2); push_exp('h132, 2);
        push_rise(0, -1); push_rise(1, 1); push_rise(3, 1);
        push_rise(0, 1);  push_rise(1, 1); push_rise(3, 1);
        wait_drain("t3");

        // 4: CONF change mid-packet only takes effect at the next ARB
        @(posedge clk);
        #1 MODE = 1'b0;
        CONF = 2'd0;
        @(negedge clk);
        push_src(0, 'hC0, 3);
        push_src(1, 'hD0, 1);
        push_exp('hC0, 3);
        push_exp('hD0, 1);
        push_rise(0, -1);
        push_rise(1, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 CONF = 2'd1;
        @(negedge clk);
        check("t4_grant_hold", 64'(GRANT), 64'(0));
        wait_drain("t4");

        // 5: reset after beat 2 of a 4-beat packet on ch1
        @(posedge clk);
        #1 mi_tready = 1'b0;
        @(negedge clk);
        push_src(1, 'hE0, 4);
        exp_q.push_back({1'b0, 32'hE2});
        exp_q.push_back({1'b1, 32'hE3});
        push_rise(1, -1);
        push_rise(1, -1);
        repeat (4) @(posedge clk);
        #1 ARESET = 1'b1;
        @(posedge clk);
        #1 ARESET = 1'b0;
        @(negedge clk);
        check("t5_valid", 64'(mi_tvalid), 64'(0));
        check("t5_data",  64'(mi_tdata),  64'(0));
        check("t5_last",  64'(mi_tlast),  64'(0));
        check("t5_grant", 64'(GRANT),     64'(0));
        check("t5_busy",  64'(BUSY),      64'(0));
        check("t5_ready", 64'(s_tready),  64'(0));
        @(posedge clk);
        #1 mi_tready = 1'b1;
        wait_drain("t5");

        // 6: idle round-robin holds grant in ARB
        @(posedge clk);
        #1 MODE = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_busy",  64'(BUSY),      64'(0));
            check("t6_grant", 64'(GRANT),     64'(1));
            check("t6_valid", 64'(mi_tvalid), 64'(0));
        end

        check("end_exp_empty",  64'(exp_q.size()),  64'(0));
        check("end_rise_empty", 64'(rise_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
